scroll_text_gen: RTL and testbench
==================================

# scroll_text_gen

Parametrised scrolling-text source for the multiplexed 7-segment display path. It concatenates two selectable words from an internal character ROM, separated by a programmable blank gap. The text scrolls right-to-left across DIGITS character slots at a divided step rate. It adds loop/one-shot modes, pause, and status pulses. Its output feeds the existing per-digit character decoder; codes are 5-bit, and 30 means blank.

## Interface
- DIGITS, 4, number of display character slots (1..8)
- STEP_DIV, 25_000_000, clk cycles per scroll step (>=1); 1 means step every cycle
- GAP, 1, blank characters inserted between first and second word (0..7)
- MAX_LEN, 8, ROM slots per message (>= longest message)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- first_sel  in  2  message index for first word
- second_sel  in  2  message index for second word
- mode  in  1  0 = loop forever, 1 = one-shot
- pause  in  1  1 freezes step counter and scroll state
- disp  out  5*DIGITS  character codes; bits [5*DIGITS-1 -: 5] = leftmost slot
- busy  out  1  1 while a pass is in progress
- done  out  1  one-cycle pulse when a one-shot pass completes
- wrap  out  1  one-cycle pulse when a loop pass restarts

## Operation
- ROM, fixed, 4 messages. Length = codes before the first 31 terminator:
  - msg0 = 16,14,22,22,0 (len 5)
  - msg1 = 23,0,0,13,11,24,14 (len 7)
  - msg2 = 22,18,0,20,22,13 (len 6)
  - msg3 = empty (len 0)
- One pass is the following character stream, in order:
  - first word;
  - GAP blanks, only if both words are non-empty;
  - second word;
  - DIGITS blanks (flush).
  - Pass length L = len1 + gap + len2 + DIGITS.
- Scroll step:
  - all slots shift one position left;
  - the next stream character enters the rightmost slot;
  - the leftmost character is discarded.
- FSM states: FIRST, GAP, SECOND, FLUSH, DONE. An index counter is 8-bit and is cleared on each state entry.
  - Transitions occur on the step that consumes the last character of a state.
  - Zero-length states are skipped in the same step.
  - After FLUSH with mode=0: go to FIRST and pulse wrap.
  - After FLUSH with mode=1: go to DONE and pulse done.
- DONE behaviour:
  - disp holds all blanks and busy=0;
  - exits only on reset or a restart event.
- Restart event: first_sel, second_sel or mode differ between their two sync registers. A restart sets:
  - disp to all blanks;
  - the step counter to 0;
  - state to FIRST, index to 0;
  - busy to 1.
- Priority: reset > restart > pause > step.
  - Restart is honoured during pause.
  - A step coinciding with a restart is dropped.
- Both words empty: pass is DIGITS flush blanks only. Loop wraps every DIGITS steps; one-shot ends after DIGITS steps.

## Timing
- Reset values:
  - disp = all 30;
  - busy = 1, state FIRST, index 0, step counter 0;
  - done = 0, wrap = 0;
  - sync registers load the current inputs, so there is no spurious restart.
- Step counter: runs 0..STEP_DIV-1 and steps on the edge where counter == STEP_DIV-1. The first step after reset deasserts occurs STEP_DIV edges later.
- Select/mode latency:
  - an input change before edge E0 is captured in sync stage 1 at E0;
  - restart is applied at E1;
  - blank disp is visible after E1;
  - the new words are used from then on.
- done and wrap are registered and assert in the cycle following the final flush step edge, for exactly one clk.
- pause=1: counter and state are held at their current values and disp is unchanged. Stepping resumes from the held counter value after deassertion.
- Reset mid-pass overrides everything on that edge.

## Test plan
- STEP_DIV=1, DIGITS=4, GAP=1, first=0, second=2, mode=0, release reset:
  - after 5 steps disp = 14,22,22,0;
  - step 6 gives 22,22,0,30;
  - wrap pulses once per 16 steps;
  - step 17 inserts 16.
- mode=1, first=1, second=3:
  - L = 11;
  - done pulses once, after the 11th step;
  - afterwards disp = 30,30,30,30 and busy=0;
  - disp is stable for 50 further cycles.
- Mid-scroll (step 3), change second_sel from 2 to 1:
  - disp is all 30 two edges later;
  - the next step inserts 16 (restart from char 0 of msg0).
- pause=1 for 20 cycles at step 4 with STEP_DIV=3:
  - disp is frozen;
  - after release, the next step occurs within 3 cycles, with no skipped character.
- Both words msg3, mode=0: disp stays all 30 and wrap pulses every 4 steps.
- Assert reset at step 7 with STEP_DIV=1:
  - next cycle disp all 30, done=0, wrap=0;
  - after release the sequence replays identically to scenario 1.

Source files
------------

// File: rtl/scroll_text_gen.sv
// Scrolling-text source for the multiplexed 7-segment display.
// Streams first word, optional blank gap, second word and a blank flush
// right-to-left across DIGITS character slots at a divided step rate.
module scroll_text_gen #(
  parameter int DIGITS   = 4,
  parameter int STEP_DIV = 25_000_000,
  parameter int GAP      = 1,
  parameter int MAX_LEN  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          first_sel,
  input  logic [1:0]          second_sel,
  input  logic                mode,
  input  logic                pause,
  output logic [5*DIGITS-1:0] disp,
  output logic                busy,
  output logic                done,
  output logic                wrap
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [4:0] BLANK = 5'd30;
  localparam logic [4:0] TERM  = 5'd31;

  typedef enum logic [2:0] {S_FIRST, S_GAP, S_SECOND, S_FLUSH, S_DONE} state_t;

  // Number of characters before the terminator in each ROM message.
  function automatic logic [7:0] msg_len(input logic [1:0] sel);
    case (sel)
      2'd0:    return 8'd5;
      2'd1:    return 8'd7;
      2'd2:    return 8'd6;
      default: return 8'd0;
    endcase
  endfunction

  // Fixed character ROM; anything past a message's end reads as terminator.
  function automatic logic [4:0] rom_char(input logic [1:0] sel, input logic [7:0] idx);
    logic [4:0] c;
    c = TERM;
    if (idx < 8'(MAX_LEN)) begin
      case (sel)
        2'd0: case (idx)
          8'd0: c = 5'd16; 8'd1: c = 5'd14; 8'd2: c = 5'd22; 8'd3: c = 5'd22;
          8'd4: c = 5'd0;  default: c = TERM;
        endcase
        2'd1: case (idx)
          8'd0: c = 5'd23; 8'd1: c = 5'd0;  8'd2: c = 5'd0;  8'd3: c = 5'd13;
          8'd4: c = 5'd11; 8'd5: c = 5'd24; 8'd6: c = 5'd14; default: c = TERM;
        endcase
        2'd2: case (idx)
          8'd0: c = 5'd22; 8'd1: c = 5'd18; 8'd2: c = 5'd0;  8'd3: c = 5'd20;
          8'd4: c = 5'd22; 8'd5: c = 5'd13; default: c = TERM;
        endcase
        default: c = TERM;
      endcase
    end
    return c;
  endfunction

  // Two-stage capture of {mode, second_sel, first_sel}; a difference between
  // the stages marks a restart, and stage 2 drives the active selection.
  logic [4:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic [7:0]          idx_q, idx_d;
  logic [5*DIGITS-1:0] disp_q, disp_d;
  logic                done_q, done_d, wrap_q, wrap_d;

  logic [1:0]          first_a, second_a;
  logic                mode_a, restart;
  logic [7:0]          len1, len2, gap_len, cur_len;
  state_t              eff;
  logic [4:0]          ch;
  logic [5*DIGITS+4:0] shifted;

  assign first_a  = sync2_q[1:0];
  assign second_a = sync2_q[3:2];
  assign mode_a   = sync2_q[4];
  assign restart  = (sync1_q != sync2_q);

  // Next-state, scroll shift and status pulses.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    sync1_d = {mode, second_sel, first_sel};
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    len1    = msg_len(first_a);
    len2    = msg_len(second_a);
    gap_len = (len1 != 8'd0 && len2 != 8'd0) ? 8'(GAP) : 8'd0;

    // Zero-length states are skipped within the same step.
    eff = state_q;
    if (eff == S_FIRST  && len1    == 8'd0) eff = S_GAP;
    if (eff == S_GAP    && gap_len == 8'd0) eff = S_SECOND;
    if (eff == S_SECOND && len2    == 8'd0) eff = S_FLUSH;

    case (eff)
      S_FIRST:  begin cur_len = len1;       ch = rom_char(first_a, idx_q);  end
      S_GAP:    begin cur_len = gap_len;    ch = BLANK;                     end
      S_SECOND: begin cur_len = len2;       ch = rom_char(second_a, idx_q); end
      S_FLUSH:  begin cur_len = 8'(DIGITS); ch = BLANK;                     end
      default:  begin cur_len = 8'd0;       ch = BLANK;                     end
    endcase
    shifted = {disp_q, ch};

    if (restart) begin
      disp_d  = {DIGITS{BLANK}};
      cnt_d   = '0;
      state_d = S_FIRST;
      idx_d   = 8'd0;
    end else if (!pause) begin
      if (cnt_q == CW'(STEP_DIV - 1)) begin
        cnt_d = '0;
        if (state_q != S_DONE) begin
          disp_d = shifted[5*DIGITS-1:0];
          if (idx_q == cur_len - 8'd1) begin
            idx_d = 8'd0;
            case (eff)
              S_FIRST:  state_d = S_GAP;
              S_GAP:    state_d = S_SECOND;
              S_SECOND: state_d = S_FLUSH;
              default: begin
                if (mode_a) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                end else begin
                  state_d = S_FIRST;
                  wrap_d  = 1'b1;
                end
              end
            endcase
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = eff;
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset; sync stages load live inputs.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= {mode, second_sel, first_sel};
      sync2_q <= {mode, second_sel, first_sel};
      cnt_q   <= '0;
      state_q <= S_FIRST;
      idx_q   <= 8'd0;
      disp_q  <= {DIGITS{BLANK}};
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign disp = disp_q;
  assign busy = (state_q != S_DONE);
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scroll_text_gen.sv
// Self-checking bench: a character-stream model pushes expected outputs to a
// scoreboard before each edge; they are popped and compared after the edge.
module tb_scroll_text_gen;

  logic        clk = 1'b0;
  logic        reset, pause, mode;
  logic [1:0]  first_sel, second_sel;
  logic [19:0] disp;
  logic        busy, done, wrap;

  logic        b_reset, b_pause;
  logic [19:0] b_disp;
  logic        b_busy, b_done, b_wrap;

  always #5 clk = ~clk;

  scroll_text_gen #(.DIGITS(4), .STEP_DIV(1), .GAP(1), .MAX_LEN(8)) u_dut (
    .clk(clk), .reset(reset), .first_sel(first_sel), .second_sel(second_sel),
    .mode(mode), .pause(pause), .disp(disp), .busy(busy), .done(done), .wrap(wrap)
  );

  scroll_text_gen #(.DIGITS(4), .STEP_DIV(3), .GAP(1), .MAX_LEN(8)) u_dut3 (
    .clk(clk), .reset(b_reset), .first_sel(2'd0), .second_sel(2'd2),
    .mode(1'b0), .pause(b_pause), .disp(b_disp), .busy(b_busy), .done(b_done), .wrap(b_wrap)
  );

  typedef struct packed {
    logic [19:0] disp;
    logic        wrap;
    logic        done;
    logic        busy;
  } exp_t;

  typedef int q_t[$];

  exp_t sb_q[$];
  q_t   msgs[4];
  int   stream[$];
  int   pos;
  logic [19:0] m_disp;
  bit   m_mode, m_done;
  int   b_cnt;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Builds the full pass stream for a word pair and resets the model.
  task automatic build(input int f, input int s, input bit m);
    stream.delete();
    foreach (msgs[f][i]) stream.push_back(msgs[f][i]);
    if (msgs[f].size() != 0 && msgs[s].size() != 0) stream.push_back(30);
    foreach (msgs[s][i]) stream.push_back(msgs[s][i]);
    for (int i = 0; i < 4; i++) stream.push_back(30);
    pos    = 0;
    m_disp = {4{5'd30}};
    m_mode = m;
    m_done = 1'b0;
  endtask

  task automatic model_step(output bit w, output bit d);
    w = 1'b0;
    d = 1'b0;
    if (!m_done) begin
      m_disp = {m_disp[14:0], 5'(stream[pos])};
      pos++;
      if (pos == stream.size()) begin
        pos = 0;
        if (m_mode) begin
          d      = 1'b1;
          m_done = 1'b1;
        end else begin
          w = 1'b1;
        end
      end
    end
  endtask

  // One clock: optionally advance the model, push expectation, compare after edge.
  task automatic cycle(input bit use_b, input bit stepping, input string tag);
    bit   w, d;
    exp_t e, got;
    w = 1'b0;
    d = 1'b0;
    if (stepping) model_step(w, d);
    sb_q.push_back('{disp: m_disp, wrap: w, done: d, busy: !m_done});
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    got = use_b ? '{disp: b_disp, wrap: b_wrap, done: b_done, busy: b_busy}
                : '{disp: disp,   wrap: wrap,   done: done,   busy: busy};
    check({tag, ".disp"}, 32'(got.disp), 32'(e.disp));
    check({tag, ".wrap"}, 32'(got.wrap), 32'(e.wrap));
    check({tag, ".done"}, 32'(got.done), 32'(e.done));
    check({tag, ".busy"}, 32'(got.busy), 32'(e.busy));
  endtask

  task automatic b_cycle(input string tag);
    bit st;
    st = 1'b0;
    if (!b_pause) begin
      if (b_cnt == 2) begin
        st    = 1'b1;
        b_cnt = 0;
      end else begin
        b_cnt++;
      end
    end
    cycle(1'b1, st, tag);
  endtask

  // Select change: one normal edge, then a restart edge that blanks the display.
  task automatic restart_to(input int f, input int s, input bit m, input string tag);
    first_sel  = 2'(f);
    second_sel = 2'(s);
    mode       = m;
    cycle(1'b0, 1'b1, {tag, "_e0"});
    build(f, s, m);
    cycle(1'b0, 1'b0, {tag, "_e1"});
  endtask

  initial begin
    msgs[0] = '{16, 14, 22, 22, 0};
    msgs[1] = '{23, 0, 0, 13, 11, 24, 14};
    msgs[2] = '{22, 18, 0, 20, 22, 13};
    msgs[3].delete();

    reset = 1'b1; pause = 1'b0; mode = 1'b0; first_sel = 2'd0; second_sel = 2'd2;
    b_reset = 1'b1; b_pause = 1'b0;

    // Pause on the STEP_DIV=3 instance, frozen mid-count after the 4th step.
    build(0, 2, 1'b0);
    cycle(1'b1, 1'b0, "b_reset");
    b_reset = 1'b0;
    b_cnt   = 0;
    for (int i = 0; i < 13; i++) b_cycle("b_run");
    b_pause = 1'b1;
    for (int i = 0; i < 20; i++) b_cycle("b_pause");
    b_pause = 1'b0;
    for (int i = 0; i < 12; i++) b_cycle("b_resume");

    // Reset state, then loop mode with msg0 + msg2 over more than two passes.
    build(0, 2, 1'b0);
    cycle(1'b0, 1'b0, "reset");
    reset = 1'b0;
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, "loop02");

    // One-shot msg1 + empty msg3, then 50 quiet cycles in DONE.
    restart_to(1, 3, 1'b1, "rs13");
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b1, "oneshot");
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, "idle");

    // Mid-scroll change of second word.
    restart_to(0, 2, 1'b0, "rs02");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, "pre");
    restart_to(0, 1, 1'b0, "rs01");
    cycle(1'b0, 1'b1, "first_after");
    check("insert16", 32'(disp[4:0]), 32'd16);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, "loop01");

    // Both words empty: flush blanks only.
    restart_to(3, 3, 1'b0, "rs33");
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, "empty");

    // Reset at step 7, then an identical replay.
    restart_to(0, 2, 1'b0, "rs02b");
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, "pre_rst");
    reset = 1'b1;
    build(0, 2, 1'b0);
    cycle(1'b0, 1'b0, "mid_reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, "replay");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
